// File: rtl/nonrestoring_div.sv
// Sequential unsigned radix-2 non-restoring divider, one quotient bit per clock.
// Ports: clk, rst_n, start/dividend/divisor in; busy, done, quotient, remainder, div_by_zero out.
module nonrestoring_div #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]    state;
  logic [N:0]    p;
  logic [N:0]    d;
  logic [N-1:0]  q;
  logic [CW-1:0] count;

  logic [N:0]    p_sh;
  logic [N:0]    p_nx;
  logic [N-1:0]  rem_fix;
  logic          last;

  // Shift {P,Q} left, then add or subtract D
  // depending on the sign of the old P.
  always_comb begin
    p_sh    = {p[N-1:0], q[N-1]};
    p_nx    = p[N] ? (p_sh + d) : (p_sh - d);
    rem_fix = p[N] ? (p[N-1:0] + d[N-1:0])
                   : p[N-1:0];
    last    = (count == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      p           <= '0;
      d           <= '0;
      q           <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            d <= {1'b0, divisor};
            q <= dividend;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              p     <= '0;
              count <= '0;
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          p     <= p_nx;
          q     <= {q[N-2:0], ~p_nx[N]};
          count <= count + CW'(1);
          // busy drops once the last quotient
          // bit is formed; FIX only registers.
          if (last) begin
            busy  <= 1'b0;
            state <= S_FIX;
          end
        end
        S_FIX: begin
          remainder   <= rem_fix;
          quotient    <= q;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_div.sv
// Self-checking bench for nonrestoring_div.
// Table vectors, scoreboard on done, corner sequences, random run.
module tb_nonrestoring_div;

  localparam int N = 32;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  vec_t sb[$];

  nonrestoring_div #(.N(N), .CW(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] a,
                              input logic [N-1:0] b);
    vec_t v;
    v.a = a;
    v.b = b;
    if (b == '0) begin
      v.q = '1;
      v.r = a;
      v.z = 1'b1;
    end else begin
      v.q = a / b;
      v.r = a % b;
      v.z = 1'b0;
    end
    return v;
  endfunction

  // Scoreboard: compare on every done pulse.
  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      vec_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1 expected none");
      end else begin
        e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(e.q));
        check("remainder", 64'(remainder), 64'(e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(e.z));
      end
    end
  end

  // Drive one request; returns #1 after accepting edge.
  task automatic issue(input vec_t v);
    @(negedge clk);
    start    = 1'b1;
    dividend = v.a;
    divisor  = v.b;
    sb.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Issue and wait for done; lat counts edges after accept.
  task automatic go(input vec_t v,
                    output int lat,
                    output int bcnt);
    issue(v);
    lat  = -1;
    bcnt = 0;
    if (busy) bcnt++;
    if (done) begin
      lat = 0;
      return;
    end
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        return;
      end
    end
  endtask

  vec_t tbl[10];
  vec_t v;
  int   lat;
  int   bc;
  int   dc0;
  logic [N-1:0] ra;
  logic [N-1:0] rb;

  initial begin
    tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
    tbl[3] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
    tbl[4] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    tbl[5] = '{32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1};
    tbl[6] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    tbl[7] = '{32'd1000, 32'd3, 32'd333, 32'd1, 1'b0};
    tbl[8] = '{32'd77, 32'd7, 32'd11, 32'd0, 1'b0};
    tbl[9] = '{32'h8000_0000, 32'd3, 32'd715827882, 32'd2, 1'b0};

    #3 rst_n = 1'b0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quot", 64'(quotient), 64'd0);
    check("rst_rem", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 100/7: latency and busy width.
    go(tbl[0], lat, bc);
    check("lat_100_7", 64'(lat), 64'd33);
    check("busy_cycles", 64'(bc), 64'd32);

    // Divide by zero: done on accept edge, no busy.
    go(tbl[5], lat, bc);
    check("lat_dbz", 64'(lat), 64'd0);
    check("busy_dbz", 64'(bc), 64'd0);
    go(tbl[6], lat, bc);
    check("lat_9_3", 64'(lat), 64'd33);

    // Table sweep.
    for (int i = 0; i < 10; i++) begin
      go(tbl[i], lat, bc);
      check("tbl_lat", 64'(lat), tbl[i].b == 0 ? 64'd0 : 64'd33);
    end

    // Start while busy is ignored.
    dc0 = done_cnt;
    issue(tbl[7]);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(posedge clk);
    #2;
    check("ignored_start_dones", 64'(done_cnt - dc0), 64'd1);

    // Start in done cycle is accepted.
    go(tbl[7], lat, bc);
    check("first_lat", 64'(lat), 64'd33);
    go(tbl[8], lat, bc);
    check("b2b_lat", 64'(lat), 64'd33);

    // Asynchronous reset mid-division.
    issue(tbl[7]);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_quot", 64'(quotient), 64'd0);
    check("arst_rem", 64'(remainder), 64'd0);
    check("arst_dbz", 64'(div_by_zero), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (40) @(posedge clk);
    #2;
    check("no_done_after_rst", 64'(done_cnt - dc0), 64'd0);
    go(tbl[8], lat, bc);
    check("post_rst_lat", 64'(lat), 64'd33);

    // Random regression.
    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0)
        rb = '0;
      else if ($urandom_range(0, 1) == 1)
        rb = $urandom;
      else
        rb = $urandom_range(1, 1000);
      v = mk(ra, rb);
      go(v, lat, bc);
      if (lat < 0) check("rand_timeout", 64'(lat), 64'd33);
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
